// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW hazard detection,
// cache-miss/branch/hazard arbitration and saturating lost-cycle counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             ex_wb_en,
  input  logic             ex_mem_r_en,
  input  logic [3:0]       ex_dest,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             branch_taken,
  input  logic             cache_ready,
  input  logic             cnt_clr,
  output logic             pc_freeze,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             cache_freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] MISS    = 2'b01;
  localparam logic [1:0] BRFLUSH = 2'b10;

  logic [1:0] state_q, state_d;
  logic       m1, m2, hz, miss, br_flush, hz_stall;

  // NOTE: every signal assigned in an always_comb gets a value on every path,
  // here by computing each one unconditionally, so no latch can be inferred.
  always_comb begin
    m1 = ex_wb_en  & ((ex_dest  == id_src1) | (id_two_src & (ex_dest  == id_src2)));
    m2 = mem_wb_en & ((mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2)));
    // With forwarding only a load in EX can't be bypassed; BRFLUSH means ID is a bubble.
    hz = id_valid & (fwd_en ? (ex_mem_r_en & m1) : (m1 | m2)) & (state_q != BRFLUSH);
    miss     = ~cache_ready;
    br_flush = cache_ready & branch_taken;
    hz_stall = cache_ready & ~branch_taken & hz;
  end

  // Flushes are masked during a miss: the stage registers let flush win over
  // freeze, so an unmasked flush would wipe the frozen contents.
  assign cache_freeze = ~rst & miss;
  assign pc_freeze    = ~rst & (miss | hz_stall);
  assign ifid_flush   = ~rst & br_flush;
  assign idex_flush   = ~rst & (br_flush | hz_stall);

  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN, MISS: begin
        if (miss)              state_d = MISS;
        else if (branch_taken) state_d = BRFLUSH;
        else                   state_d = RUN;
      end
      BRFLUSH:                 state_d = miss ? MISS : RUN;
      default:                 state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign state = state_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + 1'b1 : c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      miss_cnt  <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, hz_stall);
      flush_cnt <= sat_inc(flush_cnt, br_flush);
      miss_cnt  <= sat_inc(miss_cnt, miss);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (4-bit counters so
// saturation is reachable in a short run).
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam logic [1:0] RUN = 2'b00, MISS = 2'b01, BRFLUSH = 2'b10;

  logic clk = 1'b0;
  logic rst;
  logic fwd_en, id_valid, id_two_src, ex_wb_en, ex_mem_r_en, mem_wb_en;
  logic branch_taken, cache_ready, cnt_clr;
  logic [3:0] id_src1, id_src2, ex_dest, mem_dest;
  logic pc_freeze, ifid_flush, idex_flush, cache_freeze;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, miss_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_dest(ex_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
    .cache_ready(cache_ready), .cnt_clr(cnt_clr), .pc_freeze(pc_freeze),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .cache_freeze(cache_freeze),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .miss_cnt(miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controls packed as {pc_freeze, ifid_flush, idex_flush, cache_freeze}.
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, pc_freeze, ifid_flush, idex_flush, cache_freeze}, {28'd0, exp});
  endtask

  task automatic check_regs(input string tag, input logic [1:0] st,
                            input int sc, input int fc, input int mc);
    check({tag, ".state"}, {30'd0, state}, {30'd0, st});
    check({tag, ".stall_cnt"}, {28'd0, stall_cnt}, sc);
    check({tag, ".flush_cnt"}, {28'd0, flush_cnt}, fc);
    check({tag, ".miss_cnt"}, {28'd0, miss_cnt}, mc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fwd_en = 0; id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    ex_wb_en = 0; ex_mem_r_en = 0; ex_dest = 0; mem_wb_en = 0; mem_dest = 0;
    branch_taken = 0; cache_ready = 1; cnt_clr = 0;
    tick(); tick();
    check_ctl("reset_ctl", 4'b0000);
    check_regs("reset", RUN, 0, 0, 0);
    rst = 1'b0;

    // Load-use hazard with forwarding on
    fwd_en = 1; id_valid = 1; id_src1 = 3; ex_wb_en = 1; ex_mem_r_en = 1; ex_dest = 3;
    #1 check_ctl("load_use", 4'b1010);
    tick();
    check_regs("load_use_edge", RUN, 1, 0, 0);

    // MEM-stage match on src2 without forwarding
    ex_wb_en = 0; ex_mem_r_en = 0; fwd_en = 0;
    id_src2 = 5; id_two_src = 1; mem_wb_en = 1; mem_dest = 5;
    #1 check_ctl("nofwd_mem_src2", 4'b1010);
    fwd_en = 1;
    #1 check_ctl("fwd_no_load", 4'b0000);
    fwd_en = 0; id_two_src = 0;
    #1 check_ctl("src2_unused", 4'b0000);
    id_two_src = 1; id_valid = 0;
    #1 check_ctl("id_invalid", 4'b0000);
    id_valid = 1;
    #1 check_ctl("hz_back", 4'b1010);

    // Branch beats hazard
    branch_taken = 1;
    #1 check_ctl("branch_over_hz", 4'b0110);
    tick();
    check_regs("brflush", BRFLUSH, 1, 1, 0);
    branch_taken = 0;
    #1 check_ctl("brflush_hz_suppressed", 4'b0000);
    tick();
    check_regs("after_brflush", RUN, 1, 1, 0);
    check_ctl("hz_after_brflush", 4'b1010);
    mem_wb_en = 0;
    #1 check_ctl("hz_cleared", 4'b0000);

    // Cache miss with a pending branch held
    cache_ready = 0; branch_taken = 1;
    for (int i = 1; i <= 4; i++) begin
      #1 check_ctl($sformatf("miss_ctl_%0d", i), 4'b1001);
      tick();
      check_regs($sformatf("miss_%0d", i), MISS, 1, 1, i);
    end
    cache_ready = 1;
    #1 check_ctl("miss_release_branch", 4'b0110);
    tick();
    check_regs("miss_to_brflush", BRFLUSH, 1, 2, 4);
    check_ctl("second_branch", 4'b0110);
    tick();
    check_regs("brflush_to_run", RUN, 1, 3, 4);
    tick();
    check_regs("brflush_again", BRFLUSH, 1, 4, 4);
    branch_taken = 0; cache_ready = 0;
    #1 check_ctl("brflush_miss_ctl", 4'b1001);
    tick();
    check_regs("brflush_to_miss", MISS, 1, 4, 5);

    // Asynchronous reset mid-miss
    #2 rst = 1'b1;
    #1 check_ctl("async_rst_ctl", 4'b0000);
    check_regs("async_rst", RUN, 0, 0, 0);
    cache_ready = 1;
    #1 rst = 1'b0;

    // Saturation, then clear with an active hazard
    fwd_en = 0; id_valid = 1; mem_wb_en = 1; mem_dest = 5; id_src2 = 5; id_two_src = 1;
    #1 check_ctl("sat_hz", 4'b1010);
    for (int i = 1; i <= 15; i++) tick();
    check_regs("sat_15", RUN, 15, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    check_regs("sat_20", RUN, 15, 0, 0);
    cnt_clr = 1;
    tick();
    check_regs("cnt_clr", RUN, 0, 0, 0);
    cnt_clr = 0;
    tick();
    check_regs("after_clr", RUN, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Detects RAW hazards between the instruction in ID and the instructions held in the ID/EX and EX/MEM stage registers.
- Arbitrates between three stall sources (cache miss, taken branch, data hazard) and drives the freeze/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Keeps saturating performance counters of lost cycles.

Parameters:
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous, active-high reset.
fwd_en  input  1  1 = forwarding unit active; only load-use hazards stall.
id_valid  input  1  ID holds a real instruction.
id_src1  input  4  Rn index of the ID instruction.
id_src2  input  4  Rm/Rd index of the ID instruction.
id_two_src  input  1  ID instruction reads id_src2.
ex_wb_en  input  1  WB_EN at the ID/EX register output.
ex_mem_r_en  input  1  MEM_R_EN at the ID/EX register output.
ex_dest  input  4  Dest at the ID/EX register output.
mem_wb_en  input  1  WB_EN at the EX/MEM register output.
mem_dest  input  4  Dest at the EX/MEM register output.
branch_taken  input  1  EX resolved a taken branch this cycle.
cache_ready  input  1  Data cache can complete this cycle; 0 = miss in progress.
cnt_clr  input  1  synchronous clear of all counters.
pc_freeze  output  1  hold PC and the IF/ID register.
ifid_flush  output  1  clear IF/ID.
idex_flush  output  1  load a bubble into ID/EX.
cache_freeze  output  1  freeze every stage register.
state  output  2  00 RUN, 01 MISS, 10 BRFLUSH.
stall_cnt  output  CNT_W  hazard-stall cycles.
flush_cnt  output  CNT_W  branch flushes.
miss_cnt  output  CNT_W  cache-freeze cycles.

Behaviour:
Reset:
- All outputs 0; state = RUN; counters = 0.
- Reset asserted mid-miss or mid-flush returns to RUN immediately.

Hazard term hz (combinational):
- m1 = (ex_wb_en & ex_dest==id_src1) | (id_two_src & ex_wb_en & ex_dest==id_src2).
- m2 = same form using mem_wb_en and mem_dest.
- fwd_en=0: hz = id_valid & (m1 | m2).
- fwd_en=1: hz = id_valid & ex_mem_r_en & m1.

Output priority (combinational, same cycle): cache miss > branch > hazard.
- cache_ready=0: cache_freeze=1 and pc_freeze=1; ifid_flush and idex_flush are forced to 0.
  - Reason: the stage registers give flush priority over freeze, so an unmasked flush would destroy frozen state.
  - branch_taken stays stable while ID/EX is frozen. It is serviced on the first cycle cache_ready=1.
- Else if branch_taken: ifid_flush=1, idex_flush=1, pc_freeze=0 (PC loads the target). hz is ignored.
- Else if hz: pc_freeze=1, idex_flush=1, ifid_flush=0.
- Else: all controls 0.

FSM (registered; state output is the register value):
- RUN -> MISS when cache_ready=0.
- RUN -> BRFLUSH when cache_ready=1 and branch_taken=1.
- MISS -> MISS while cache_ready=0.
- MISS -> BRFLUSH when cache_ready=1 and branch_taken=1; MISS -> RUN when cache_ready=1 and branch_taken=0.
- BRFLUSH lasts exactly one cycle and marks the wrong-path shadow:
  - hz is suppressed (ID holds a bubble).
  - A second branch_taken is honoured normally.
  - Next state is MISS if cache_ready=0, else RUN.

Counters:
- Increment at a clock edge when the condition held in the preceding cycle:
  - stall_cnt: hz-driven stall.
  - flush_cnt: branch flush.
  - miss_cnt: cache_ready=0.
- Saturate at 2^CNT_W-1, no wrap.
- cnt_clr has priority over increment.

Latency:
- All control outputs are combinational from the current inputs (zero cycle).
- Only state and the counters are registered.

Test Plan:
- Reset, then fwd_en=1, id_valid=1, id_src1=3, ex_wb_en=1, ex_mem_r_en=1, ex_dest=3 for 1 cycle -> pc_freeze=1, idex_flush=1, ifid_flush=0; stall_cnt=1 after the edge.
- fwd_en=0, id_src2=5, id_two_src=1, mem_wb_en=1, mem_dest=5 -> stall asserted. Same stimulus with fwd_en=1 and ex_mem_r_en=0 -> no stall.
- branch_taken=1 together with an active hz -> ifid_flush=1, idex_flush=1, pc_freeze=0; state=BRFLUSH for 1 cycle, then RUN; flush_cnt=1.
- cache_ready=0 for 4 cycles with branch_taken=1 held:
  - During the 4 cycles: cache_freeze=1, both flushes 0, state=MISS, miss_cnt reaches 4.
  - First ready cycle: flushes=1, then state BRFLUSH.
- rst pulsed during MISS -> all outputs 0 and state=RUN asynchronously; counters 0.
- CNT_W=4, hazard held 20 cycles -> stall_cnt saturates at 15. Then cnt_clr=1 together with hz -> stall_cnt=0.
